// File: rtl/axis_s2mm_engine.sv
// Stream-to-memory write engine: takes one 72-bit command, writes the payload stream as
// 4 KB-safe INCR bursts with one burst outstanding, then returns an 8-bit status byte.
module axis_s2mm_engine #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_MAX_BURST_LEN    = 16,
    parameter logic [2:0]  C_PROT             = 3'b010,
    parameter logic [3:0]  C_CACHE            = 4'b0011
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [71:0]                     S_AXIS_CMD_TDATA,
    input  logic                            S_AXIS_CMD_TVALID,
    output logic                            S_AXIS_CMD_TREADY,
    output logic [7:0]                      M_AXIS_STS_TDATA,
    output logic                            M_AXIS_STS_TVALID,
    input  logic                            M_AXIS_STS_TREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {StIdle, StChk, StAw, StW, StB, StSts} state_t;

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_tag;
    logic [19:0]   r_beats_left;
    logic [8:0]    r_len;
    logic [8:0]    r_beats;
    logic          r_cmd_bad, r_pad, r_interr, r_slverr, r_decerr;

    logic [AW-1:0] w_addr_adv;
    logic [19:0]   w_left_adv;
    logic [8:0]    w_awlen_full;
    logic          w_last_burst, w_w_hs, w_s_hs, w_cmd_hs, w_okay, w_unused_cmd;

    // Beats allowed from this address: clamped by remaining beats, max burst, 4 KB page end.
    function automatic logic [8:0] calc_len(input logic [19:0] left, input logic [8:0] off_beats);
        logic [9:0]  page_beats;
        logic [19:0] cap;
        page_beats = 10'd512 - {1'b0, off_beats};
        cap        = 20'(C_MAX_BURST_LEN);
        if ({10'd0, page_beats} < cap) cap = {10'd0, page_beats};
        if (left < cap) cap = left;
        return 9'(cap);
    endfunction

    assign w_addr_adv   = r_addr + (AW'(r_len) << 3);
    assign w_left_adv   = r_beats_left - {11'd0, r_len};
    assign w_last_burst = (r_beats_left == {11'd0, r_len});
    assign w_w_hs       = M_AXI_WVALID && M_AXI_WREADY;
    assign w_s_hs       = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_cmd_hs     = S_AXIS_CMD_TVALID && S_AXIS_CMD_TREADY;
    assign w_okay       = !(r_interr || r_decerr || r_slverr);
    assign w_awlen_full = r_len - 9'd1;
    assign w_unused_cmd = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31:23]};

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWLEN   = w_awlen_full[7:0];
    assign M_AXI_AWSIZE  = 3'b011;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWPROT  = C_PROT;
    assign M_AXI_AWCACHE = C_CACHE;

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next      = r_state;
        S_AXIS_CMD_TREADY = 1'b0;
        M_AXIS_STS_TVALID = 1'b0;
        M_AXIS_STS_TDATA  = 8'h00;
        S_AXIS_TREADY     = 1'b0;
        M_AXI_AWVALID     = 1'b0;
        M_AXI_WVALID      = 1'b0;
        M_AXI_WDATA       = '0;
        M_AXI_WSTRB       = '0;
        M_AXI_WLAST       = 1'b0;
        M_AXI_BREADY      = 1'b0;
        case (r_state)
            StIdle: begin
                S_AXIS_CMD_TREADY = 1'b1;
                if (S_AXIS_CMD_TVALID) w_state_next = StChk;
            end
            StChk: w_state_next = r_cmd_bad ? StSts : StAw;
            StAw: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) w_state_next = StW;
            end
            StW: begin
                M_AXI_WLAST = (r_beats == 9'd1);
                // After an early TLAST the burst is finished with strobe-less filler beats.
                if (r_pad) begin
                    M_AXI_WVALID = 1'b1;
                end else begin
                    M_AXI_WVALID  = S_AXIS_TVALID;
                    S_AXIS_TREADY = M_AXI_WREADY;
                    M_AXI_WDATA   = S_AXIS_TDATA;
                    M_AXI_WSTRB   = '1;
                end
                if (w_w_hs && r_beats == 9'd1) w_state_next = StB;
            end
            StB: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) w_state_next = (w_left_adv != 20'd0 && !r_pad) ? StAw : StSts;
            end
            StSts: begin
                M_AXIS_STS_TVALID = 1'b1;
                M_AXIS_STS_TDATA  = {w_okay, r_slverr, r_decerr, r_interr, r_tag};
                if (M_AXIS_STS_TREADY) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_tag        <= 4'd0;
            r_beats_left <= 20'd0;
            r_len        <= 9'd0;
            r_beats      <= 9'd0;
            r_cmd_bad    <= 1'b0;
            r_pad        <= 1'b0;
            r_interr     <= 1'b0;
            r_slverr     <= 1'b0;
            r_decerr     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: if (w_cmd_hs) begin
                    r_addr       <= AW'(S_AXIS_CMD_TDATA[63:32]);
                    r_tag        <= S_AXIS_CMD_TDATA[67:64];
                    r_beats_left <= S_AXIS_CMD_TDATA[22:3];
                    r_cmd_bad    <= (S_AXIS_CMD_TDATA[22:0] == 23'd0) ||
                                    (S_AXIS_CMD_TDATA[2:0] != 3'd0) ||
                                    (S_AXIS_CMD_TDATA[34:32] != 3'd0);
                    r_pad        <= 1'b0;
                    r_interr     <= 1'b0;
                    r_slverr     <= 1'b0;
                    r_decerr     <= 1'b0;
                end
                StChk: begin
                    if (r_cmd_bad) r_interr <= 1'b1;
                    else           r_len    <= calc_len(r_beats_left, r_addr[11:3]);
                end
                StAw: if (M_AXI_AWREADY) r_beats <= r_len;
                StW: begin
                    if (w_w_hs) r_beats <= r_beats - 9'd1;
                    if (w_s_hs && S_AXIS_TLAST && !(w_last_burst && r_beats == 9'd1)) begin
                        r_pad    <= 1'b1;
                        r_interr <= 1'b1;
                    end
                end
                StB: if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP == 2'b10) r_slverr <= 1'b1;
                    if (M_AXI_BRESP == 2'b11) r_decerr <= 1'b1;
                    r_addr       <= w_addr_adv;
                    r_beats_left <= w_left_adv;
                    r_len        <= calc_len(w_left_adv, w_addr_adv[11:3]);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_s2mm_engine.sv
// Directed-vector bench for axis_s2mm_engine: a command table driven through a cycle-level
// AXI slave / stream source model with random backpressure, plus a mid-transfer reset sequence.
module tb_axis_s2mm_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] S_AXIS_CMD_TDATA;
    logic        S_AXIS_CMD_TVALID, S_AXIS_CMD_TREADY;
    logic [7:0]  M_AXIS_STS_TDATA;
    logic        M_AXIS_STS_TVALID, M_AXIS_STS_TREADY;
    logic [63:0] S_AXIS_TDATA;
    logic        S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_AWPROT;
    logic [1:0]  M_AXI_AWBURST;
    logic [3:0]  M_AXI_AWCACHE;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;

    always #5 clk = ~clk;

    axis_s2mm_engine #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(64),
        .C_MAX_BURST_LEN   (16),
        .C_PROT            (3'b010),
        .C_CACHE           (4'b0011)
    ) dut (
        .clk(clk), .rst(rst),
        .S_AXIS_CMD_TDATA(S_AXIS_CMD_TDATA), .S_AXIS_CMD_TVALID(S_AXIS_CMD_TVALID),
        .S_AXIS_CMD_TREADY(S_AXIS_CMD_TREADY),
        .M_AXIS_STS_TDATA(M_AXIS_STS_TDATA), .M_AXIS_STS_TVALID(M_AXIS_STS_TVALID),
        .M_AXIS_STS_TREADY(M_AXIS_STS_TREADY),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    typedef struct packed {
        logic [31:0]      saddr;
        logic [22:0]      btt;
        logic [3:0]       tag;
        logic [7:0]       tlast_beat;  // 1-based beat carrying TLAST, 0 = never
        logic [1:0]       bresp0;
        logic [1:0]       bresp_rest;
        logic [2:0]       n_bursts;
        logic [2:0][31:0] exp_addr;
        logic [2:0][7:0]  exp_len;
        logic [7:0]       n_pads;
        logic [7:0]       exp_sts;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] saddr, input int btt, input int tag,
                                input int tl, input logic [1:0] br0, input logic [1:0] br1,
                                input int nb, input logic [31:0] a0, input int l0,
                                input logic [31:0] a1, input int l1, input logic [31:0] a2,
                                input int l2, input int pads, input logic [7:0] sts);
        vec_t v;
        v.saddr       = saddr;
        v.btt         = 23'(btt);
        v.tag         = 4'(tag);
        v.tlast_beat  = 8'(tl);
        v.bresp0      = br0;
        v.bresp_rest  = br1;
        v.n_bursts    = 3'(nb);
        v.exp_addr[0] = a0;
        v.exp_addr[1] = a1;
        v.exp_addr[2] = a2;
        v.exp_len[0]  = 8'(l0);
        v.exp_len[1]  = 8'(l1);
        v.exp_len[2]  = 8'(l2);
        v.n_pads      = 8'(pads);
        v.exp_sts     = sts;
        return v;
    endfunction

    function automatic logic [63:0] beat_data(input int vi, input int idx);
        return {16'hA5C3, vi[15:0], idx[31:0]};
    endfunction

    task automatic run_vec(input vec_t v, input int vi);
        int   cmd_beats = int'(v.btt >> 3);
        int   src_total, s_idx = 0, aw_n = 0, b_n = 0, w_tot = 0, w_pad = 0;
        int   w_in_burst = 0, cur_len = 0, b_wait = 0, b_cycle = -10, exp_w = 0;
        logic cmd_sent = 1'b0, s_valid = 1'b0, m_pad = 1'b0, b_pend = 1'b0, done = 1'b0;
        logic sts_seen = 1'b0, aw_hold = 1'b0, w_hold = 1'b0, sts_hold = 1'b0;
        logic [127:0] aw_hold_val = '0, w_hold_val = '0, sts_hold_val = '0;
        src_total = (v.n_bursts == 3'd0) ? 0 :
                    (v.tlast_beat != 8'd0) ? int'(v.tlast_beat) : cmd_beats;
        for (int k = 0; k < int'(v.n_bursts); k++) exp_w += int'(v.exp_len[k]) + 1;

        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            S_AXIS_CMD_TDATA  = {4'h0, v.tag, v.saddr, 9'h0, v.btt};
            S_AXIS_CMD_TVALID = !cmd_sent;
            M_AXI_AWREADY     = ($urandom_range(3) != 0);
            M_AXI_WREADY      = ($urandom_range(3) != 0);
            M_AXIS_STS_TREADY = ($urandom_range(2) != 0);
            if (!s_valid && s_idx < src_total && $urandom_range(3) != 0) s_valid = 1'b1;
            S_AXIS_TVALID = s_valid;
            S_AXIS_TDATA  = beat_data(vi, s_idx);
            S_AXIS_TLAST  = s_valid && v.tlast_beat != 8'd0 && s_idx == int'(v.tlast_beat) - 1;
            if (b_pend && b_wait > 0) b_wait--;
            M_AXI_BVALID = b_pend && b_wait == 0;
            M_AXI_BRESP  = (b_n == 0) ? v.bresp0 : v.bresp_rest;
            #1;
            if (aw_hold) chk("aw_stable", {M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWLEN}, aw_hold_val);
            if (w_hold)  chk("w_stable", {M_AXI_WVALID, M_AXI_WLAST, M_AXI_WSTRB, M_AXI_WDATA},
                             w_hold_val);
            if (sts_hold) chk("sts_stable", {M_AXIS_STS_TVALID, M_AXIS_STS_TDATA}, sts_hold_val);

            if (S_AXIS_CMD_TVALID && S_AXIS_CMD_TREADY) cmd_sent = 1'b1;

            aw_hold = 1'b0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                chk("aw_after_b", b_n, aw_n);
                chk("aw_attr", {M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWPROT, M_AXI_AWCACHE},
                    {3'b011, 2'b01, 3'b010, 4'b0011});
                if (aw_n < int'(v.n_bursts)) begin
                    chk("awaddr", M_AXI_AWADDR, v.exp_addr[aw_n]);
                    chk("awlen", M_AXI_AWLEN, v.exp_len[aw_n]);
                    cur_len = int'(v.exp_len[aw_n]);
                end else begin
                    chk("aw_extra", aw_n, v.n_bursts);
                end
                aw_n++;
                w_in_burst = 0;
            end else if (M_AXI_AWVALID) begin
                aw_hold     = 1'b1;
                aw_hold_val = {1'b1, M_AXI_AWADDR, M_AXI_AWLEN};
            end

            w_hold = 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                chk("wlast", M_AXI_WLAST, w_in_burst == cur_len);
                if (m_pad) begin
                    chk("pad_beat", {S_AXIS_TREADY, M_AXI_WSTRB, M_AXI_WDATA}, '0);
                    w_pad++;
                end else begin
                    chk("data_beat", {S_AXIS_TVALID, S_AXIS_TREADY, M_AXI_WSTRB, M_AXI_WDATA},
                        {1'b1, 1'b1, 8'hFF, beat_data(vi, s_idx)});
                end
                w_tot++;
                w_in_burst++;
                if (M_AXI_WLAST) begin
                    b_pend = 1'b1;
                    b_wait = int'($urandom_range(2));
                end
            end else if (M_AXI_WVALID) begin
                w_hold     = 1'b1;
                w_hold_val = {1'b1, M_AXI_WLAST, M_AXI_WSTRB, M_AXI_WDATA};
            end

            if (M_AXI_BVALID && M_AXI_BREADY) begin
                b_pend  = 1'b0;
                b_n++;
                b_cycle = cyc;
            end

            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                if (S_AXIS_TLAST && s_idx + 1 < cmd_beats) m_pad = 1'b1;
                s_idx++;
                s_valid = 1'b0;
            end

            sts_hold = 1'b0;
            if (M_AXIS_STS_TVALID) begin
                if (!sts_seen && v.n_bursts != 3'd0) chk("sts_latency", cyc, b_cycle + 1);
                sts_seen = 1'b1;
                if (M_AXIS_STS_TREADY) begin
                    chk("status", M_AXIS_STS_TDATA, v.exp_sts);
                    done = 1'b1;
                end else begin
                    sts_hold     = 1'b1;
                    sts_hold_val = {1'b1, M_AXIS_STS_TDATA};
                end
            end
        end
        chk("completed", done, 1'b1);
        chk("aw_count", aw_n, v.n_bursts);
        chk("b_count", b_n, v.n_bursts);
        chk("w_total", w_tot, exp_w);
        chk("pad_count", w_pad, v.n_pads);
    endtask

    task automatic reset_mid_w();
        logic in_w = 1'b0, sent = 1'b0;
        for (int c = 0; c < 50 && !in_w; c++) begin
            @(negedge clk);
            S_AXIS_CMD_TDATA  = {4'h0, 4'h2, 32'h0000_A000, 9'h0, 23'd64};
            S_AXIS_CMD_TVALID = !sent;
            M_AXI_AWREADY     = 1'b1;
            M_AXI_WREADY      = 1'b1;
            M_AXI_BVALID      = 1'b0;
            S_AXIS_TVALID     = 1'b1;
            S_AXIS_TLAST      = 1'b0;
            S_AXIS_TDATA      = 64'h1234;
            #1;
            if (S_AXIS_CMD_TVALID && S_AXIS_CMD_TREADY) sent = 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY) in_w = 1'b1;
        end
        chk("reached_w", in_w, 1'b1);
        @(negedge clk);
        S_AXIS_CMD_TVALID = 1'b0;
        M_AXIS_STS_TREADY = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXIS_STS_TVALID,
                           S_AXIS_TREADY}, 5'b0);
        chk("rst_cmd_ready", S_AXIS_CMD_TREADY, 1'b1);
        chk("rst_sts_data", M_AXIS_STS_TDATA, 8'h00);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            chk("no_status_after_rst", {M_AXIS_STS_TVALID, M_AXI_AWVALID, M_AXI_WVALID}, 3'b0);
        end
        S_AXIS_TVALID = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        S_AXIS_CMD_TDATA  = '0;
        S_AXIS_CMD_TVALID = 1'b0;
        M_AXIS_STS_TREADY = 1'b0;
        S_AXIS_TDATA      = '0;
        S_AXIS_TLAST      = 1'b0;
        S_AXIS_TVALID     = 1'b0;
        M_AXI_AWREADY     = 1'b0;
        M_AXI_WREADY      = 1'b0;
        M_AXI_BRESP       = 2'b00;
        M_AXI_BVALID      = 1'b0;

        vecs[0]  = mk(32'h1000_0000, 64, 3, 8, 2'b00, 2'b00, 1, 32'h1000_0000, 7, 0, 0, 0, 0,
                      0, 8'h83);
        vecs[1]  = mk(32'h0000_0FC0, 256, 5, 32, 2'b00, 2'b00, 3, 32'h0FC0, 7, 32'h1000, 15,
                      32'h1080, 7, 0, 8'h85);
        vecs[2]  = mk(32'h0000_2000, 0, 6, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h16);
        vecs[3]  = mk(32'h0000_2004, 64, 7, 8, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h17);
        vecs[4]  = mk(32'h0000_3000, 12, 8, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h18);
        vecs[5]  = mk(32'h0000_4000, 128, 9, 3, 2'b00, 2'b00, 1, 32'h4000, 15, 0, 0, 0, 0,
                      13, 8'h19);
        vecs[6]  = mk(32'h0000_5000, 256, 10, 32, 2'b10, 2'b00, 2, 32'h5000, 15, 32'h5080, 15,
                      0, 0, 0, 8'h4A);
        vecs[7]  = mk(32'h0000_6000, 256, 11, 32, 2'b11, 2'b00, 2, 32'h6000, 15, 32'h6080, 15,
                      0, 0, 0, 8'h2B);
        vecs[8]  = mk(32'h0000_7FF8, 16, 12, 2, 2'b00, 2'b00, 2, 32'h7FF8, 0, 32'h8000, 0,
                      0, 0, 0, 8'h8C);
        vecs[9]  = mk(32'h0000_8000, 24, 13, 0, 2'b00, 2'b00, 1, 32'h8000, 2, 0, 0, 0, 0,
                      0, 8'h8D);
        vecs[10] = mk(32'h0000_9000, 256, 14, 16, 2'b00, 2'b00, 1, 32'h9000, 15, 0, 0, 0, 0,
                      0, 8'h1E);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXIS_STS_TVALID,
                             S_AXIS_TREADY}, 5'b0);
        chk("reset_sts_data", M_AXIS_STS_TDATA, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);
        reset_mid_w();
        run_vec(vecs[0], 0);
        run_vec(vecs[6], 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
